// File: rtl/spi_ram_gen.sv
// spi_ram_gen: parametrised single-port RAM command slave behind an SPI
// front end. Each accepted command word carries a 2-bit opcode plus payload;
// RD_DATA returns registered read data with a one-cycle tx_valid strobe.
// Optional auto-increment lets write/read bursts stream through memory, and
// address commands that fall outside the memory are rejected with addr_err.

module spi_ram_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] din,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  addr_err
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Last legal address; pointer wrap compares against this explicitly so that
  // non-power-of-two depths wrap correctly.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  // Depth widened by one bit so a full 2^ADDR_WIDTH depth is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  opcode_e               opcode;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_WIDTH-1:0] payload_addr;
  logic                  addr_ok;
  logic                  rd_accept;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  addr_err_q, addr_err_d;
  logic                  mem_we;

  assign opcode       = opcode_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign payload      = din[DATA_WIDTH-1:0];
  assign payload_addr = payload[ADDR_WIDTH-1:0];
  // An address is legal only if it lies below the depth and no payload bits
  // above the pointer width are set.
  assign addr_ok      = ({1'b0, payload_addr} < DEPTH_LIM) &&
                        ((payload >> ADDR_WIDTH) == '0);
  assign rd_accept    = rx_valid && (opcode == OP_RD_DATA);

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  // Next-state decode: command execution, pointer updates and response strobes.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    state_d    = ST_IDLE;

    unique case (state_q)
      ST_IDLE: state_d = rd_accept ? ST_RESP : ST_IDLE;
      ST_RESP: state_d = rd_accept ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (rx_valid) begin
      unique case (opcode)
        OP_WR_ADDR: begin
          if (addr_ok) wr_ptr_d = payload_addr;
          else         addr_err_d = 1'b1;
        end
        OP_WR_DATA: begin
          mem_we = 1'b1;
          if (AUTO_INC != 0) wr_ptr_d = next_ptr(wr_ptr_q);
        end
        OP_RD_ADDR: begin
          if (addr_ok) rd_ptr_d = payload_addr;
          else         addr_err_d = 1'b1;
        end
        OP_RD_DATA: begin
          dout_d = mem[rd_ptr_q];
          if (AUTO_INC != 0) rd_ptr_d = next_ptr(rd_ptr_q);
        end
        default: ;
      endcase
    end

    tx_valid_d = (state_d == ST_RESP);
  end

  // Control FSM and registered outputs; reset clears pointers and strobes at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      dout_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_valid_q <= tx_valid_d;
      dout_q     <= dout_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= payload;
  end

  assign tx_valid = tx_valid_q;
  assign dout     = dout_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_gen.sv
// tb_spi_ram_gen: directed scoreboard bench for spi_ram_gen. dut0 uses the
// default 256x8 configuration without auto-increment; dut1 uses a 200-entry
// memory with auto-increment to exercise bursts, wrap and range rejection.

module tb_spi_ram_gen;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid0 = 1'b0;
  logic       rx_valid1 = 1'b0;
  logic [9:0] din0 = '0;
  logic [9:0] din1 = '0;
  logic       tx_valid0, tx_valid1;
  logic [7:0] dout0, dout1;
  logic       addr_err0, addr_err1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         err_exp0 = 0;
  int         err_exp1 = 0;
  int         err_seen0 = 0;
  int         err_seen1 = 0;

  spi_ram_gen dut0 (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid0),
    .din      (din0),
    .tx_valid (tx_valid0),
    .dout     (dout0),
    .addr_err (addr_err0)
  );

  spi_ram_gen #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .MEM_DEPTH  (200),
    .AUTO_INC   (1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid1),
    .din      (din1),
    .tx_valid (tx_valid1),
    .dout     (dout1),
    .addr_err (addr_err1)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one command to the chosen DUT across one rising edge; the other
  // DUT is left idle. rx_valid stays high so successive calls stream.
  task automatic applyStimulus(input int which, input logic [1:0] op,
                               input logic [7:0] payload);
    if (which == 0) begin
      rx_valid0 = 1'b1;
      din0      = {op, payload};
      rx_valid1 = 1'b0;
    end else begin
      rx_valid1 = 1'b1;
      din1      = {op, payload};
      rx_valid0 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Read command with its expected response queued for the monitor.
  task automatic readExpect(input int which, input logic [7:0] value);
    if (which == 0) exp_q0.push_back(value);
    else            exp_q1.push_back(value);
    applyStimulus(which, RD_DATA, 8'h00);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every
  // tx_valid strobe and tallies addr_err strobes.
  always @(negedge clk) begin
    if (tx_valid0) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut0_unexpected_tx_valid: got dout=0x%0h, expected no response", dout0);
      end else begin
        checkOutput("dut0_dout", {24'h0, dout0}, {24'h0, exp_q0.pop_front()});
      end
    end
    if (tx_valid1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut1_unexpected_tx_valid: got dout=0x%0h, expected no response", dout1);
      end else begin
        checkOutput("dut1_dout", {24'h0, dout1}, {24'h0, exp_q1.pop_front()});
      end
    end
    if (addr_err0) err_seen0++;
    if (addr_err1) err_seen1++;
  end

  initial begin
    // Reset state
    #2;
    checkOutput("reset_tx_valid0", {31'h0, tx_valid0}, 32'h0);
    checkOutput("reset_dout0",     {24'h0, dout0},     32'h0);
    checkOutput("reset_addr_err0", {31'h0, addr_err0}, 32'h0);
    checkOutput("reset_tx_valid1", {31'h0, tx_valid1}, 32'h0);
    checkOutput("reset_dout1",     {24'h0, dout1},     32'h0);
    checkOutput("reset_addr_err1", {31'h0, addr_err1}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycles(1);

    // Test 1: basic write then read, no auto-increment
    $display("[TB] basic write/read");
    applyStimulus(0, WR_ADDR, 8'd7);
    applyStimulus(0, WR_DATA, 8'h03);
    applyStimulus(0, RD_ADDR, 8'd7);
    readExpect(0, 8'h03);
    checkOutput("t1_tx_valid_high", {31'h0, tx_valid0}, 32'h1);
    idleCycles(1);
    checkOutput("t1_tx_valid_low", {31'h0, tx_valid0}, 32'h0);
    // Read-after-write on consecutive edges
    applyStimulus(0, WR_ADDR, 8'd9);
    applyStimulus(0, RD_ADDR, 8'd9);
    applyStimulus(0, WR_DATA, 8'h5A);
    readExpect(0, 8'h5A);
    idleCycles(2);

    // Test 2: auto-increment burst write and streamed burst read
    $display("[TB] burst");
    applyStimulus(1, WR_ADDR, 8'h10);
    applyStimulus(1, WR_DATA, 8'hA1);
    applyStimulus(1, WR_DATA, 8'hA2);
    applyStimulus(1, WR_DATA, 8'hA3);
    applyStimulus(1, RD_ADDR, 8'h10);
    readExpect(1, 8'hA1);
    readExpect(1, 8'hA2);
    readExpect(1, 8'hA3);
    idleCycles(2);

    // Test 3: pointers wrap from 199 to 0
    $display("[TB] wrap");
    applyStimulus(1, WR_ADDR, 8'd199);
    applyStimulus(1, WR_DATA, 8'h55);
    applyStimulus(1, WR_DATA, 8'h66);
    applyStimulus(1, RD_ADDR, 8'd199);
    readExpect(1, 8'h55);
    readExpect(1, 8'h66);
    idleCycles(2);

    // Test 4: out-of-range address commands leave pointers untouched
    $display("[TB] range");
    applyStimulus(1, WR_ADDR, 8'd5);
    applyStimulus(1, WR_DATA, 8'h11);
    applyStimulus(1, RD_ADDR, 8'd5);
    err_exp1++;
    applyStimulus(1, RD_ADDR, 8'd250);
    checkOutput("t4_addr_err_high", {31'h0, addr_err1}, 32'h1);
    readExpect(1, 8'h11);
    checkOutput("t4_addr_err_low", {31'h0, addr_err1}, 32'h0);
    err_exp1++;
    applyStimulus(1, WR_ADDR, 8'd200);
    applyStimulus(1, WR_DATA, 8'h22);
    applyStimulus(1, RD_ADDR, 8'd6);
    readExpect(1, 8'h22);
    idleCycles(2);

    // Test 5: asynchronous reset in the middle of a read stream
    $display("[TB] reset mid-burst");
    applyStimulus(1, WR_ADDR, 8'd3);
    applyStimulus(1, WR_DATA, 8'h33);
    applyStimulus(1, WR_DATA, 8'h44);
    applyStimulus(1, WR_DATA, 8'h55);
    applyStimulus(1, RD_ADDR, 8'd3);
    readExpect(1, 8'h33);
    readExpect(1, 8'h44);
    applyStimulus(1, RD_DATA, 8'h00);
    checkOutput("t5_tx_valid_before_reset", {31'h0, tx_valid1}, 32'h1);
    checkOutput("t5_dout_before_reset",     {24'h0, dout1},     32'h55);
    rx_valid1 = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_tx_valid_async_reset", {31'h0, tx_valid1}, 32'h0);
    checkOutput("t5_dout_async_reset",     {24'h0, dout1},     32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycles(1);
    readExpect(1, 8'h66);

    // Test 6: idle hold, then readback proves memory was not disturbed
    $display("[TB] idle hold");
    idleCycles(10);
    checkOutput("t6_tx_valid_idle", {31'h0, tx_valid1}, 32'h0);
    checkOutput("t6_dout_hold",     {24'h0, dout1},     32'h66);
    applyStimulus(1, RD_ADDR, 8'h10);
    readExpect(1, 8'hA1);
    readExpect(1, 8'hA2);
    readExpect(1, 8'hA3);
    applyStimulus(1, RD_ADDR, 8'd199);
    readExpect(1, 8'h55);
    applyStimulus(1, RD_ADDR, 8'd6);
    readExpect(1, 8'h22);
    applyStimulus(0, RD_ADDR, 8'd7);
    readExpect(0, 8'h03);
    applyStimulus(0, RD_ADDR, 8'd9);
    readExpect(0, 8'h5A);
    idleCycles(3);

    // Drain checks
    checkOutput("dut0_pending_reads", exp_q0.size(), 32'h0);
    checkOutput("dut1_pending_reads", exp_q1.size(), 32'h0);
    checkOutput("dut0_addr_err_count", err_seen0, err_exp0);
    checkOutput("dut1_addr_err_count", err_seen1, err_exp1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
